// File: rtl/ccsm_pkg.sv
// Shared types and the golden reference for the ccsm self-test sequencer.
package ccsm_pkg;

  // Sequencer states: idle, hold a vector, sample it, report.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_t;

  // Exhaustive test of the three-input cell.
  localparam int NUM_VEC = 8;

  // Expected {x,y} of a fault-free ccsm cell.
  function automatic logic [1:0] ccsm_golden(input logic a, input logic b, input logic c);
    return {~(c ^ (a | b)), a & b};
  endfunction

endpackage

// File: rtl/ccsm_bist_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise step unless already saturated.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ccsm_bist.sv
// Self-test sequencer for the ccsm cell: walks all eight {a,b,c} vectors,
// holds each for SETTLE cycles, samples x/y once and tallies mismatches.
module ccsm_bist
  import ccsm_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             dut_x,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_fail_vec,
  output logic             first_fail_valid
);

  // Settle counter only has to reach SETTLE-1; keep it at least one bit wide.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [2:0]       LAST_VEC    = 3'(NUM_VEC - 1);

  bist_state_t      state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic             pass_q, pass_d;
  logic [2:0]       ff_vec_q, ff_vec_d;
  logic             ff_valid_q, ff_valid_d;

  logic             err_clr;
  logic             err_inc;
  logic [1:0]       golden;
  logic             mismatch;

  // Mismatch tally lives in its own saturating counter.
  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (err_clr),
    .inc   (err_inc),
    .count (err_count)
  );

  // Compare the returned cell outputs against the reference for the current vector.
  always_comb begin
    golden   = ccsm_golden(vec_q[2], vec_q[1], vec_q[0]);
    mismatch = ({dut_x, dut_y} != golden);
  end

  // Next-state and datapath updates; abort beats start and suppresses the compare.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    settle_d   = settle_q;
    pass_d     = pass_q;
    ff_vec_d   = ff_vec_q;
    ff_valid_d = ff_valid_q;
    err_clr    = 1'b0;
    err_inc    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d    = ST_APPLY;
          vec_d      = '0;
          settle_d   = '0;
          ff_valid_d = 1'b0;
          pass_d     = 1'b0;
          err_clr    = 1'b1;
        end
      end

      ST_APPLY: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q + CNT_W'(1);
        end
      end

      ST_CHECK: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          if (mismatch) begin
            err_inc = 1'b1;
            if (!ff_valid_q) begin
              ff_vec_d   = vec_q;
              ff_valid_d = 1'b1;
            end
          end
          if (vec_q == LAST_VEC) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_APPLY;
            vec_d    = vec_q + 3'd1;
            settle_d = '0;
          end
        end
      end

      ST_DONE: begin
        // The final CHECK has already been folded into err_count.
        pass_d  = (err_count == '0);
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset returns every result to its cleared value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      settle_q   <= '0;
      pass_q     <= 1'b0;
      ff_vec_q   <= '0;
      ff_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      settle_q   <= settle_d;
      pass_q     <= pass_d;
      ff_vec_q   <= ff_vec_d;
      ff_valid_q <= ff_valid_d;
    end
  end

  // Moore outputs: the vector is only driven while a run is active.
  always_comb begin
    busy = (state_q == ST_APPLY) || (state_q == ST_CHECK);
    done = (state_q == ST_DONE);
    {a, b, c} = busy ? vec_q : 3'b000;
  end

  assign pass             = pass_q;
  assign first_fail_vec   = ff_vec_q;
  assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_ccsm_bist.sv
// Bench for ccsm_bist: two instances (default parameters, and SETTLE=3/ERR_W=2)
// each beside a behavioural ccsm with injectable per-vector output flips.
module tb_ccsm_bist;
  import ccsm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: SETTLE=2, ERR_W=4.
  logic       start0 = 1'b0, abort0 = 1'b0;
  logic       a0, b0, c0, x0, y0, busy0, done0, pass0, ffval0;
  logic [3:0] err0;
  logic [2:0] ffv0;
  logic [7:0] fx0 = '0, fy0 = '0;

  // Instance 1: SETTLE=3, ERR_W=2.
  logic       start1 = 1'b0, abort1 = 1'b0;
  logic       a1, b1, c1, x1, y1, busy1, done1, pass1, ffval1;
  logic [1:0] err1;
  logic [2:0] ffv1;
  logic [7:0] fx1 = '0, fy1 = '0;

  ccsm_bist #(.SETTLE(2), .ERR_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .a(a0), .b(b0), .c(c0), .dut_x(x0), .dut_y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_vec(ffv0), .first_fail_valid(ffval0)
  );

  ccsm_bist #(.SETTLE(3), .ERR_W(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .a(a1), .b(b1), .c(c1), .dut_x(x1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_valid(ffval1)
  );

  // Behavioural ccsm cells with per-vector output inversion masks.
  always_comb begin
    {x0, y0} = ccsm_golden(a0, b0, c0) ^ {fx0[{a0, b0, c0}], fy0[{a0, b0, c0}]};
    {x1, y1} = ccsm_golden(a1, b1, c1) ^ {fx1[{a1, b1, c1}], fy1[{a1, b1, c1}]};
  end

  // Observation mux for whichever instance the current test drives.
  logic       sel = 1'b0;
  logic       o_busy, o_done, o_pass, o_ffval;
  logic [2:0] o_abc, o_ffv;
  logic [3:0] o_err;
  always_comb begin
    o_busy  = sel ? busy1 : busy0;
    o_done  = sel ? done1 : done0;
    o_pass  = sel ? pass1 : pass0;
    o_ffval = sel ? ffval1 : ffval0;
    o_ffv   = sel ? ffv1 : ffv0;
    o_abc   = sel ? {a1, b1, c1} : {a0, b0, c0};
    o_err   = sel ? {2'b00, err1} : err0;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] cur_fx, cur_fy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v; else start0 = v;
  endtask

  task automatic set_abort(input logic v);
    if (sel) abort1 = v; else abort0 = v;
  endtask

  task automatic set_faults(input logic [7:0] fx, input logic [7:0] fy);
    cur_fx = fx;
    cur_fy = fy;
    if (sel) begin fx1 = fx; fy1 = fy; end
    else     begin fx0 = fx; fy0 = fy; end
  endtask

  function automatic int settle_of();
    return sel ? 3 : 2;
  endfunction

  function automatic int err_max();
    return sel ? 3 : 15;
  endfunction

  // Number of faulty vectors among the first n.
  function automatic int faulty_below(input int n);
    int cnt = 0;
    for (int v = 0; v < n; v++) if (cur_fx[v] | cur_fy[v]) cnt++;
    return cnt;
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, ".busy"},  32'(o_busy),  0);
    check({tag, ".done"},  32'(o_done),  0);
    check({tag, ".pass"},  32'(o_pass),  0);
    check({tag, ".abc"},   32'(o_abc),   0);
    check({tag, ".err"},   32'(o_err),   0);
    check({tag, ".ffv"},   32'(o_ffv),   0);
    check({tag, ".ffval"}, 32'(o_ffval), 0);
  endtask

  // One full run on the selected instance, checked cycle by cycle against
  // the arithmetic schedule: vector j/(SETTLE+1) is driven j cycles after accept.
  task automatic do_run(input string tag, input bit hold);
    int period = settle_of() + 1;
    int mism   = faulty_below(NUM_VEC);
    int first  = -1;
    int exp_e  = (mism > err_max()) ? err_max() : mism;
    for (int v = NUM_VEC - 1; v >= 0; v--) if (cur_fx[v] | cur_fy[v]) first = v;

    @(negedge clk) set_start(1'b1);
    @(negedge clk);
    if (!hold) set_start(1'b0);
    for (int j = 0; j < NUM_VEC * period; j++) begin
      check({tag, ".busy"}, 32'(o_busy), 1);
      check({tag, ".done"}, 32'(o_done), 0);
      check({tag, ".abc"},  32'(o_abc),  32'(j / period));
      @(negedge clk);
    end
    check({tag, ".done_pulse"}, 32'(o_done),  1);
    check({tag, ".busy_done"},  32'(o_busy),  0);
    check({tag, ".abc_done"},   32'(o_abc),   0);
    check({tag, ".err"},        32'(o_err),   32'(exp_e));
    check({tag, ".ffval"},      32'(o_ffval), 32'(first >= 0));
    if (first >= 0) check({tag, ".ffv"}, 32'(o_ffv), 32'(first));
    check({tag, ".pass_in_done"}, 32'(o_pass), 0);
    @(negedge clk);
    check({tag, ".done_low"}, 32'(o_done), 0);
    check({tag, ".busy_idle"}, 32'(o_busy), 0);
    check({tag, ".pass"},     32'(o_pass), 32'(mism == 0));
    check({tag, ".err_hold"}, 32'(o_err),  32'(exp_e));
  endtask

  initial begin
    int mism;
    bit saw_done;

    // Reset state of both instances.
    #1;
    sel = 1'b0; check_cleared("rst0");
    sel = 1'b1; check_cleared("rst1");
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    // Fault-free, default parameters.
    sel = 1'b0; set_faults(8'h00, 8'h00); do_run("clean", 1'b0);
    // y stuck-at-0: only vectors 110 and 111 have golden y=1.
    sel = 1'b0; set_faults(8'h00, 8'b1100_0000); do_run("y_sa0", 1'b0);
    // x inverted on a 2-bit counter: saturates at 3.
    sel = 1'b1; set_faults(8'hFF, 8'h00); do_run("x_inv", 1'b0);

    // Randomised fault masks on random instances.
    for (int r = 0; r < 8; r++) begin
      sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) set_faults(8'h00, 8'h00);
      else set_faults(8'($urandom), 8'($urandom));
      do_run($sformatf("rnd%0d", r), 1'b0);
    end

    // Abort in the first APPLY cycle of vector 3.
    sel = 1'b0;
    set_faults(8'($urandom) | 8'h01, 8'($urandom));
    mism = faulty_below(3);
    @(negedge clk) set_start(1'b1);
    @(negedge clk) set_start(1'b0);
    repeat (3 * 3) @(negedge clk);
    check("abort.at_vec3", 32'(o_abc), 3);
    set_abort(1'b1);
    @(negedge clk) set_abort(1'b0);
    check("abort.busy", 32'(o_busy), 0);
    check("abort.abc",  32'(o_abc),  0);
    check("abort.done", 32'(o_done), 0);
    check("abort.err",  32'(o_err),  32'(mism));
    check("abort.pass", 32'(o_pass), 0);
    check("abort.ffv",  32'(o_ffv),  0);
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (o_done) saw_done = 1'b1;
    end
    check("abort.no_done", 32'(saw_done), 0);
    check("abort.err_hold", 32'(o_err), 32'(mism));
    set_faults(8'h00, 8'h00); do_run("after_abort", 1'b0);

    // Asynchronous reset in the middle of vector 4's CHECK cycle.
    sel = 1'b0; set_faults(8'h0F, 8'h00);
    @(negedge clk) set_start(1'b1);
    @(negedge clk) set_start(1'b0);
    repeat (4 * 3 + 2) @(negedge clk);
    check("rstmid.in_check", 32'(o_abc), 4);
    check("rstmid.err_pre",  32'(o_err), 4);
    #2 rst = 1'b1;
    #1 check_cleared("rstmid");
    @(negedge clk) rst = 1'b0;
    set_faults(8'h00, 8'h00); do_run("after_rst", 1'b0);

    // start and abort together in IDLE: stays idle.
    sel = 1'b1;
    @(negedge clk) begin set_start(1'b1); set_abort(1'b1); end
    repeat (3) begin
      @(negedge clk);
      check("start_abort.busy", 32'(o_busy), 0);
    end
    set_start(1'b0); set_abort(1'b0);

    // start held high: mid-run start ignored, next run after DONE+IDLE.
    sel = 1'b0; set_faults(8'h00, 8'h00);
    do_run("held", 1'b1);
    @(negedge clk);
    check("held.rerun_busy", 32'(o_busy), 1);
    check("held.rerun_abc",  32'(o_abc),  0);
    check("held.rerun_pass", 32'(o_pass), 0);
    set_start(1'b0); set_abort(1'b1);
    @(negedge clk) set_abort(1'b0);
    check("held.stop", 32'(o_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ccsm_bist.md
# ccsm_bist

Self-test sequencer for the `ccsm` combinational cell (x = ~(c ^ (a|b)), y = a & b).
- Drives all eight {a,b,c} input vectors into an external `ccsm` instance and waits a programmable settle time per vector.
- Samples x/y, compares them against a golden model, and reports pass/fail, a saturating mismatch count and the first failing vector.
- Sits beside the `ccsm` instance in the lab top level, under a start/done handshake from the board controller or testbench.

## Interface
- `SETTLE`, default 2: cycles each vector is held before sampling; legal range ≥1.
- `ERR_W`, default 4: width of the mismatch counter.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level; sampled only in IDLE.
- `abort` in 1: terminates a run; has priority over `start`.
- `a`, `b`, `c` out 1 each: vector driven to `ccsm`, {a,b,c} = current vector index.
- `dut_x`, `dut_y` in 1 each: `ccsm` outputs returned to the block.
- `busy` out 1: high in APPLY and CHECK.
- `done` out 1: one-cycle pulse, high in the DONE state.
- `pass` out 1: 1 when the last completed run had zero mismatches.
- `err_count` out ERR_W: mismatch count; saturates at 2^ERR_W−1.
- `first_fail_vec` out 3: {a,b,c} of the first mismatching vector.
- `first_fail_valid` out 1: `first_fail_vec` is meaningful.

## Operation
- States: IDLE, APPLY, CHECK, DONE. Moore outputs.
- Reset values: state IDLE, vec 0, a/b/c 0, busy 0, done 0, pass 0, err_count 0, first_fail_vec 0, first_fail_valid 0.
- IDLE, `abort`=1: stay in IDLE. Abort wins over a simultaneous start.
- IDLE, `start`=1, `abort`=0: go to APPLY. Clear vec, settle counter, err_count, first_fail_valid and pass.
- APPLY: drive {a,b,c}=vec and increment the settle counter. Leave for CHECK when the counter reaches SETTLE−1, so the vector is held SETTLE cycles before sampling.
- CHECK: compare {dut_x,dut_y} with golden(vec).
  - On mismatch, increment err_count (saturating).
  - If first_fail_valid=0, capture first_fail_vec=vec and set first_fail_valid.
  - The vector is still driven in CHECK; CHECK is the sample cycle.
- CHECK exit: vec=7 → DONE. Otherwise vec+1, counter 0, back to APPLY.
- DONE: done=1 and pass ← (err_count==0 including the final check), then IDLE next cycle.
- `abort`=1 in APPLY or CHECK: go to IDLE on the next edge.
  - No done pulse; pass stays 0; err_count and first_fail hold their partial values.
  - No compare occurs in an aborted CHECK cycle.
- `start` outside IDLE is ignored.
- a/b/c are 0 in IDLE and DONE.
- Results (pass, err_count, first_fail_*) hold until the next accepted start or reset.
- Asserting `rst` at any point returns everything to reset values immediately, without a clock edge.

## Timing
- Each vector takes SETTLE+1 cycles: SETTLE in APPLY, 1 in CHECK.
- done is high exactly 8·(SETTLE+1) cycles after the edge that accepted start. SETTLE=2 gives 24.
- busy rises on the accepting edge and falls when entering DONE or IDLE.
- With `start` held high continuously, runs repeat back-to-back with one DONE plus one IDLE cycle between them.
- err_count and first_fail_* update on the edge leaving CHECK; pass updates on the edge entering IDLE from DONE.

## Structure
- Package `ccsm_pkg` holds:
  - a state enum `bist_state_t`;
  - `NUM_VEC = 8`;
  - function `ccsm_golden(a,b,c)` returning {x,y} = {~(c^(a|b)), a&b}.
  - Bench scoreboards use the same function.
- One natural sub-module, `sat_counter`: parameter W; inputs clr and inc; saturating output.
- Integration wrapper `ccsm_bist_top` wires `ccsm_bist` to `ccsm`. It is not part of this block.

## Test plan
- Correct ccsm, SETTLE=2, start pulse → done exactly 24 cycles later, pass=1, err_count=0, first_fail_valid=0, a/b/c step 000..111.
- Faulty model, y stuck-at-0 → err_count=2 (vectors 110, 111), first_fail_vec=3'b110, first_fail_valid=1, pass=0.
- Faulty model, x inverted, ERR_W=2 → err_count saturates at 3, first_fail_vec=000, pass=0.
- Abort asserted during vector 3 APPLY → busy low next cycle, no done, a/b/c=000, err_count held. A following start then completes with pass=1.
- rst asserted mid-CHECK between clock edges → all outputs at reset values before the next edge; start after release runs normally.
- start and abort high together in IDLE → stays IDLE, busy=0. start held high during a run → ignored, then a new run begins after DONE+IDLE.
